// File: rtl/sift_scan_ctrl.sv
// rtl/sift_scan_ctrl.sv - SIFT descriptor window scan sequencer (optional macro: SIFT_SKIP_ZERO_MAG_EN)
//
// Walks the 16x16 window in raster order: clears the 128-bin histogram,
// then for each sample requests a gradient, runs the orientation-bin
// converter for two cycles and issues one histogram accumulate strobe.
// With SIFT_SKIP_ZERO_MAG_EN defined, samples whose magnitude is below 4
// (grad_mag[9:2]==0) skip the converter/histogram steps entirely.

module sift_scan_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       grad_req,
  output logic [3:0] grad_x,
  output logic [3:0] grad_y,
  input  logic       grad_ack,
  input  logic [9:0] grad_mag,
  output logic       conv_en,
  output logic [3:0] conv_x,
  output logic [3:0] conv_y,
  output logic       hist_we,
  output logic       clr_we,
  output logic [6:0] clr_addr,
  output logic [8:0] sample_cnt
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_LOAD  = 3'd3;
  localparam logic [2:0] ST_EMIT  = 3'd4;
  localparam logic [2:0] ST_WRITE = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  logic [2:0] state_q, state_d;
  logic [3:0] pos_x_q, pos_x_d;
  logic [3:0] pos_y_q, pos_y_d;
  logic [6:0] clr_addr_q, clr_addr_d;
  logic [8:0] sample_cnt_q, sample_cnt_d;
  logic [9:0] mag_q, mag_d;

  logic last_pos;
  logic skip_sample;
  // The latched magnitude is kept for the converter side but is not read here.
  logic unused_mag;

  assign last_pos   = (pos_x_q == 4'd15) && (pos_y_q == 4'd15);
  assign unused_mag = ^mag_q;

`ifdef SIFT_SKIP_ZERO_MAG_EN
  // Decided on the acknowledged magnitude, i.e. the value being latched.
  assign skip_sample = (grad_mag[9:2] == 8'd0);
`else
  assign skip_sample = 1'b0;
`endif

  // Next-state logic: abort overrides everything and returns to IDLE.
  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    clr_addr_d   = clr_addr_q;
    sample_cnt_d = sample_cnt_q;
    mag_d        = mag_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d      = ST_CLEAR;
            pos_x_d      = 4'd0;
            pos_y_d      = 4'd0;
            sample_cnt_d = 9'd0;
            clr_addr_d   = 7'd0;
          end
        end
        ST_CLEAR: begin
          clr_addr_d = clr_addr_q + 7'd1;
          if (clr_addr_q == 7'd127) begin
            state_d = ST_REQ;
          end
        end
        ST_REQ: begin
          if (grad_ack) begin
            mag_d = grad_mag;
            if (skip_sample) begin
              if (last_pos) begin
                state_d = ST_DONE;
              end else begin
                state_d = ST_REQ;
                pos_x_d = pos_x_q + 4'd1;
                if (pos_x_q == 4'd15) begin
                  pos_y_d = pos_y_q + 4'd1;
                end
              end
            end else begin
              state_d = ST_LOAD;
            end
          end
        end
        ST_LOAD: state_d = ST_EMIT;
        ST_EMIT: state_d = ST_WRITE;
        ST_WRITE: begin
          sample_cnt_d = sample_cnt_q + 9'd1;
          if (last_pos) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
            pos_x_d = pos_x_q + 4'd1;
            if (pos_x_q == 4'd15) begin
              pos_y_d = pos_y_q + 4'd1;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pos_x_q      <= 4'd0;
      pos_y_q      <= 4'd0;
      clr_addr_q   <= 7'd0;
      sample_cnt_q <= 9'd0;
      mag_q        <= 10'd0;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      clr_addr_q   <= clr_addr_d;
      sample_cnt_q <= sample_cnt_d;
      mag_q        <= mag_d;
    end
  end

  // Outputs decode only from registers, so no input reaches an output combinationally.
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign grad_req   = (state_q == ST_REQ);
  assign grad_x     = pos_x_q;
  assign grad_y     = pos_y_q;
  assign conv_en    = (state_q == ST_LOAD) || (state_q == ST_EMIT);
  assign conv_x     = pos_x_q;
  assign conv_y     = pos_y_q;
  assign hist_we    = (state_q == ST_WRITE);
  assign clr_we     = (state_q == ST_CLEAR);
  assign clr_addr   = clr_addr_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_sift_scan_ctrl.sv
// tb/tb_sift_scan_ctrl.sv - self-checking bench for sift_scan_ctrl against a timeline model
module tb_sift_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, abort, grad_ack;
  logic [9:0] grad_mag;
  logic       busy, done, grad_req, conv_en, hist_we, clr_we;
  logic [3:0] grad_x, grad_y, conv_x, conv_y;
  logic [6:0] clr_addr;
  logic [8:0] sample_cnt;

  int         n_vec = 0;
  int         n_err = 0;
  int         delay_tbl [256];
  logic [9:0] mag_tbl   [256];
  bit         skip_en;

  sift_scan_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .grad_req(grad_req),
    .grad_x(grad_x), .grad_y(grad_y), .grad_ack(grad_ack), .grad_mag(grad_mag),
    .conv_en(conv_en), .conv_x(conv_x), .conv_y(conv_y),
    .hist_we(hist_we), .clr_we(clr_we), .clr_addr(clr_addr), .sample_cnt(sample_cnt)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".grad_req"}, grad_req, 0);
    check({tag, ".grad_x"}, grad_x, 0);
    check({tag, ".grad_y"}, grad_y, 0);
    check({tag, ".conv_en"}, conv_en, 0);
    check({tag, ".conv_x"}, conv_x, 0);
    check({tag, ".conv_y"}, conv_y, 0);
    check({tag, ".hist_we"}, hist_we, 0);
    check({tag, ".clr_we"}, clr_we, 0);
    check({tag, ".clr_addr"}, clr_addr, 0);
    check({tag, ".sample_cnt"}, sample_cnt, 0);
  endtask

  task automatic set_tables(input int mode);
    for (int k = 0; k < 256; k++) begin
      delay_tbl[k] = 0;
      mag_tbl[k]   = 10'd400;
      if (mode == 1) begin
        delay_tbl[k] = int'($urandom_range(0, 2));
        mag_tbl[k]   = ((k % 16) % 2 == 0) ? 10'd0 : 10'($urandom_range(4, 1023));
      end
    end
  endtask

  // One scan from IDLE; abort_k aborts in EMIT of that sample, pulse_at re-pulses start,
  // rst_at drops reset at that cycle offset from the start cycle T.
  task automatic scan(input string tag, input int abort_k, input int pulse_at, input int rst_at);
    int exp_done, req_k, wcnt, last_req, clr_cnt, done_at, wr_idx, k;
    int wr_list[$];
    bit skip_tbl [256];
    bit prev_conv, fin;

    exp_done = 129;
    wr_list.delete();
    for (int s = 0; s < 256; s++) begin
      skip_tbl[s] = skip_en && (mag_tbl[s][9:2] == 8'd0);
      exp_done += delay_tbl[s] + (skip_tbl[s] ? 1 : 4);
      if (!skip_tbl[s]) wr_list.push_back(s);
    end

    @(negedge clk);
    check({tag, ".idle_busy"}, busy, 0);
    start = 1'b1;
    abort = 1'b0;
    req_k = 0; wcnt = 0; last_req = -1; clr_cnt = 0; done_at = -1; wr_idx = 0;
    prev_conv = 1'b0; fin = 1'b0;

    for (int i = 1; i <= exp_done + 40 && !fin; i++) begin
      @(negedge clk);
      start    = (i == pulse_at);
      abort    = 1'b0;
      grad_ack = 1'b0;
      grad_mag = 10'($urandom);
      if (i == rst_at) begin
        check({tag, ".pre_rst_clr_we"}, clr_we, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_all_zero({tag, ".after_rst"});
        return;
      end
      check({tag, ".clr_we"}, clr_we, (i >= 1 && i <= 128));
      if (clr_we) begin
        check({tag, ".clr_addr"}, clr_addr, i - 1);
        clr_cnt++;
      end
      if (grad_req) begin
        check({tag, ".grad_x"}, grad_x, req_k % 16);
        check({tag, ".grad_y"}, grad_y, req_k / 16);
        if (req_k != last_req) begin
          wcnt = 0;
          last_req = req_k;
        end else begin
          wcnt++;
        end
        if (req_k < 256 && wcnt >= delay_tbl[req_k]) begin
          grad_ack = 1'b1;
          grad_mag = mag_tbl[req_k];
          req_k++;
        end
      end
      if (conv_en) begin
        k = int'(conv_y) * 16 + int'(conv_x);
        check({tag, ".conv_on_skipped"}, skip_tbl[k], 0);
        if (prev_conv && abort_k >= 0 && k == abort_k) abort = 1'b1;
      end
      prev_conv = conv_en;
      if (hist_we) begin
        if (wr_idx < wr_list.size()) begin
          check({tag, ".hist_x"}, conv_x, wr_list[wr_idx] % 16);
          check({tag, ".hist_y"}, conv_y, wr_list[wr_idx] / 16);
        end
        check({tag, ".cnt_at_we"}, sample_cnt, wr_idx);
        wr_idx++;
      end
      if (done) begin
        done_at = i;
        check({tag, ".busy_with_done"}, busy, 1);
        fin = 1'b1;
      end
      if (abort) begin
        @(negedge clk);
        abort = 1'b0;
        check({tag, ".abort_busy"}, busy, 0);
        check({tag, ".abort_req"}, grad_req, 0);
        check({tag, ".abort_conv"}, conv_en, 0);
        check({tag, ".abort_we"}, hist_we, 0);
        check({tag, ".abort_clr"}, clr_we, 0);
        check({tag, ".abort_cnt"}, sample_cnt, abort_k);
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          check({tag, ".abort_no_done"}, done, 0);
          check({tag, ".abort_stays_idle"}, busy, 0);
        end
        return;
      end
    end

    if (abort_k >= 0) check({tag, ".abort_reached"}, 0, 1);
    check({tag, ".done_cycle"}, done_at, exp_done);
    check({tag, ".clr_count"}, clr_cnt, 128);
    check({tag, ".we_count"}, wr_idx, wr_list.size());
    check({tag, ".final_cnt"}, sample_cnt, wr_list.size());
    @(negedge clk);
    check({tag, ".busy_after"}, busy, 0);
    check({tag, ".done_pulse"}, done, 0);
  endtask

  // Directed sequence of scans with modelled expectations.
  initial begin
`ifdef SIFT_SKIP_ZERO_MAG_EN
    skip_en = 1'b1;
`else
    skip_en = 1'b0;
`endif
    reset    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    grad_ack = 1'b0;
    grad_mag = 10'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    set_tables(0);
    scan("basic", -1, -1, -1);

    delay_tbl[2 * 16 + 5] = 3;
    scan("late_ack", -1, -1, -1);

    set_tables(0);
    scan("abort17", 17, -1, -1);
    scan("restart_pulse", -1, 500, -1);

    set_tables(1);
    scan("random_skip", -1, -1, -1);

    set_tables(0);
    scan("reset_clear", -1, -1, 60);
    scan("after_reset", -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sift_scan_ctrl.md
# sift_scan_ctrl

Sequencer for the SIFT descriptor datapath. Walks the 16x16 sample window in raster order, requests one gradient (magnitude/angle) per position from the gradient unit, and drives the enable and position inputs of the SIFT orientation-bin converter. It clears the 128-entry descriptor histogram before each scan and issues one histogram write strobe per converted sample. Sits between the descriptor top-level control and the gradient, converter and histogram-RAM blocks.

## Interface
Parameters:
- none; window fixed at 16x16, histogram at 128 bins (bin index bit 7 is always 0).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a scan; sampled only in IDLE
- abort  in  1  synchronous cancel; effective in any state
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the scan completes
- grad_req  out  1  gradient request, held until acknowledged
- grad_x, grad_y  out  4 each  requested sample position; stable while grad_req=1
- grad_ack  in  1  gradient valid for (grad_x, grad_y) this cycle
- grad_mag  in  10  gradient magnitude, valid with grad_ack
- conv_en  out  1  converter enable
- conv_x, conv_y  out  4 each  converter position inputs; equal to the latched sample position
- hist_we  out  1  histogram accumulate strobe (bin/value read from the converter)
- clr_we  out  1  histogram clear write strobe
- clr_addr  out  7  histogram address being cleared
- sample_cnt  out  9  number of hist_we strobes issued in the current scan, 0..256

## Operation
- States: IDLE, CLEAR, REQ, LOAD, EMIT, WRITE, DONE.
- IDLE: all strobes low. start=1 leads to CLEAR, and pos_x, pos_y, sample_cnt and clr_addr are set to 0.
- CLEAR: clr_we=1 and clr_addr increments each cycle, covering 0..127. After addr 127 the FSM moves to REQ.
- REQ: grad_req=1 and grad_x/grad_y = pos. On grad_ack, grad_mag is latched and the FSM moves to LOAD. It waits indefinitely without ack.
- LOAD: conv_en=1, which makes the converter register position, magnitude and angle. The FSM moves to EMIT.
- EMIT: conv_en=1 with inputs unchanged, which makes the converter register bin and value. The FSM moves to WRITE.
- WRITE: hist_we=1 and sample_cnt increments.
  - If pos=(15,15), the FSM moves to DONE.
  - Otherwise pos_x increments. When pos_x wraps from 15 to 0, pos_y increments. The FSM moves to REQ.
- DONE: done=1 for one cycle, then the FSM moves to IDLE.
- conv_x/conv_y follow pos in every state, and pos changes only at WRITE exit.
- start while busy is ignored. start and abort asserted in the same cycle in IDLE: abort wins and the FSM stays in IDLE.
- abort: the next state is IDLE, no done pulse, and strobes are low from the next cycle on. sample_cnt holds its value until the next start.
- reset low: the FSM goes to IDLE. pos, clr_addr, sample_cnt and the latched mag are all 0, and every output is 0.

## Timing
- Reset values: busy=0, done=0, grad_req=0, grad_x=grad_y=0, conv_en=0, conv_x=conv_y=0, hist_we=0, clr_we=0, clr_addr=0, sample_cnt=0.
- All outputs are registered or derived only from the state and position registers. There are no combinational paths from inputs to outputs.
- Reference timeline, with start sampled at cycle T and grad_ack arriving in the first REQ cycle:
  - CLEAR occupies T+1..T+128.
  - The first REQ is at T+129.
  - The WRITE for sample k is at T+132+4k.
  - The last WRITE is at T+1152, and done is at T+1153.
- Each cycle that grad_ack is late adds exactly one cycle to the timeline.

## Configuration
- Macro SIFT_SKIP_ZERO_MAG_EN.
- Defined: when the latched grad_mag[9:2]==0, the FSM goes from REQ directly to position advance. That sample gets no LOAD, EMIT or WRITE, no conv_en and no hist_we, and sample_cnt does not increment. The last-position rule still routes to DONE.
- Undefined: every sample goes through LOAD, EMIT and WRITE regardless of magnitude.

## Test plan
- Reset, then start with grad_ack tied high and grad_mag=10'd400:
  - clr_we is high for 128 cycles with clr_addr going 0..127.
  - 256 hist_we pulses occur, in raster order (0,0),(1,0)..(15,15).
  - done is at T+1153, sample_cnt=256, and busy falls with done.
- Hold grad_ack low for 3 cycles on sample (5,2): grad_x=5 and grad_y=2 stay stable, and done shifts by +3.
- Assert abort during EMIT of sample 17: the FSM is in IDLE the next cycle, there is no done, sample_cnt=17, and a following start restarts from CLEAR.
- Pulse start again at cycle T+500 of an active scan: no effect, and timing is identical to the first test.
- With SIFT_SKIP_ZERO_MAG_EN and grad_mag=0 on even x:
  - 128 hist_we pulses, sample_cnt=128.
  - No conv_en on the skipped samples.
  - done still pulses.
- Drive reset low in the middle of CLEAR: all outputs are 0 in the next cycle, and start after reset behaves like the first test.
